// File: rtl/keycode_queue.sv
// Keycode front end: synchronize and debounce the PIO keycode, queue new presses,
// and release at most one queued keycode per video frame at the end of vsync.
module keycode_queue #(
    parameter int DEPTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [7:0]                   keycode,
    input  logic                         vs,
    output logic [7:0]                   cmd,
    output logic                         cmd_new,
    output logic                         frame_tick,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]             key_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vs_sync;
    logic [7:0]             key_synced;
    logic                   vs_synced;
    logic                   vs_d;

    logic [7:0]             candidate;
    logic [CNT_W-1:0]       stable_cnt;
    logic [7:0]             accepted;
    logic                   accept;
    logic                   push;

    logic [7:0]             mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   wr_en;

    assign key_synced = key_sync[SYNC_STAGES-1];
    assign vs_synced  = vs_sync[SYNC_STAGES-1];

    // vs synchronizer resets high so releasing reset never looks like the end of a sync pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) key_sync[i] <= 8'h00;
            vs_sync    <= '1;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            key_sync[0] <= keycode;
            for (int i = 1; i < SYNC_STAGES; i++) key_sync[i] <= key_sync[i-1];
            vs_sync    <= {vs_sync[SYNC_STAGES-2:0], vs};
            vs_d       <= vs_synced;
            frame_tick <= vs_synced & ~vs_d;
        end
    end

    assign accept = (stable_cnt == CNT_MAX) && (candidate != accepted);
    assign push   = accept && (candidate != 8'h00);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            candidate  <= 8'h00;
            stable_cnt <= '0;
            accepted   <= 8'h00;
        end else begin
            if (key_synced != candidate) begin
                candidate  <= key_synced;
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
            if (accept) accepted <= candidate;
        end
    end

    // A push into a full FIFO only lands if the same cycle frees a slot
    assign full  = (count == CW'(DEPTH));
    assign pop   = frame_tick && (count != '0);
    assign wr_en = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= candidate;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cmd      <= 8'h00;
            cmd_new  <= 1'b0;
        end else begin
            cmd_new <= pop;
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                cmd    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && full && !pop) overflow <= 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_keycode_queue.sv
// Directed bench for keycode_queue: push latency, debounce, FIFO ordering/overflow,
// frame-tick popping, coincident push/pop and asynchronous reset.
module tb_keycode_queue;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       vs;
    logic [7:0] cmd;
    logic       cmd_new;
    logic       frame_tick;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    keycode_queue #(.DEPTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .vs         (vs),
        .cmd        (cmd),
        .cmd_new    (cmd_new),
        .frame_tick (frame_tick),
        .count      (count),
        .overflow   (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(posedge Clk); #1 keycode = k;
        repeat (10) @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (10) @(posedge Clk);
    endtask

    task automatic do_frame(output int ticks, output int news);
        ticks = 0;
        news  = 0;
        @(posedge Clk); #1 vs = 1'b0;
        repeat (4) @(posedge Clk);
        #1 vs = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (frame_tick) ticks++;
            if (cmd_new) news++;
        end
    endtask

    task automatic frame_expect(input string tag, input logic [7:0] exp_cmd, input int exp_news);
        int t, n;
        do_frame(t, n);
        check_eq({tag, "_ticks"}, t, 1);
        check_eq({tag, "_news"}, n, exp_news);
        check_eq({tag, "_cmd"}, cmd, exp_cmd);
    endtask

    // keycode changes just before edge 0; vs rises just before edge 3 so the pop lands on edge 6 with the push
    task automatic coincide(input logic [7:0] k, output int news);
        news = 0;
        @(posedge Clk); #1 vs = 1'b0;
        repeat (4) @(posedge Clk);
        #1 keycode = k;
        repeat (3) @(posedge Clk);
        #1 vs = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (cmd_new) news++;
        end
        keycode = 8'h00;
        repeat (10) @(posedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, news;
        Reset_n = 1'b0;
        keycode = 8'h00;
        vs      = 1'b1;
        #12;
        check_eq("rst_cmd", cmd, 8'h00);
        check_eq("rst_count", count, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_tick", frame_tick, 0);
        @(negedge Clk); Reset_n = 1'b1;
        ticks = 0;
        repeat (10) begin @(negedge Clk); if (frame_tick) ticks++; end
        check_eq("idle_after_rst_tick", ticks, 0);

        // single press: push visible exactly at edge 6
        @(posedge Clk); #1 keycode = 8'h1A;
        repeat (7) @(negedge Clk);
        check_eq("push_lat_e5", count, 0);
        @(negedge Clk);
        check_eq("push_lat_e6", count, 1);
        repeat (8) @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (10) @(posedge Clk);
        check_eq("hold_no_repush", count, 1);
        frame_expect("single", 8'h1A, 1);
        check_eq("single_count", count, 0);

        // glitch rejection, then press/release/press of the same key
        @(posedge Clk); #1 keycode = 8'h07;
        repeat (2) @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (12) @(posedge Clk);
        check_eq("glitch_count", count, 0);
        press(8'h07);
        press(8'h07);
        check_eq("repress_count", count, 2);
        frame_expect("repress1", 8'h07, 1);
        frame_expect("repress2", 8'h07, 1);
        check_eq("repress_drain", count, 0);

        // overflow with wrapped pointers
        press(8'h04);
        press(8'h07);
        press(8'h16);
        press(8'h1A);
        check_eq("ovf_pre_flag", overflow, 0);
        press(8'h2C);
        check_eq("ovf_count", count, 4);
        check_eq("ovf_flag", overflow, 1);
        frame_expect("ovf_pop1", 8'h04, 1);
        frame_expect("ovf_pop2", 8'h07, 1);
        frame_expect("ovf_pop3", 8'h16, 1);
        frame_expect("ovf_pop4", 8'h1A, 1);
        check_eq("ovf_drain", count, 0);
        check_eq("ovf_sticky", overflow, 1);

        // asynchronous reset mid-operation
        press(8'h11);
        press(8'h22);
        check_eq("mid_count", count, 2);
        @(negedge Clk); #2 Reset_n = 1'b0;
        #1;
        check_eq("async_rst_count", count, 0);
        check_eq("async_rst_cmd", cmd, 8'h00);
        check_eq("async_rst_ovf", overflow, 0);
        @(negedge Clk); Reset_n = 1'b1;
        ticks = 0;
        repeat (10) begin @(negedge Clk); if (frame_tick) ticks++; end
        check_eq("rerst_tick", ticks, 0);
        check_eq("rerst_count", count, 0);

        // push coinciding with a tick while full
        press(8'h04);
        press(8'h07);
        press(8'h16);
        press(8'h1A);
        check_eq("full_pre_count", count, 4);
        coincide(8'h2C, news);
        check_eq("full_coin_news", news, 1);
        check_eq("full_coin_cmd", cmd, 8'h04);
        check_eq("full_coin_count", count, 4);
        check_eq("full_coin_ovf", overflow, 0);
        frame_expect("full_pop1", 8'h07, 1);
        frame_expect("full_pop2", 8'h16, 1);
        frame_expect("full_pop3", 8'h1A, 1);
        frame_expect("full_pop4", 8'h2C, 1);

        // push coinciding with a tick while empty: no bypass
        coincide(8'h16, news);
        check_eq("empty_coin_news", news, 0);
        check_eq("empty_coin_cmd", cmd, 8'h2C);
        check_eq("empty_coin_count", count, 1);
        frame_expect("empty_next", 8'h16, 1);
        check_eq("empty_next_count", count, 0);

        // idle frames
        frame_expect("idle1", 8'h16, 0);
        frame_expect("idle2", 8'h16, 0);
        frame_expect("idle3", 8'h16, 0);
        check_eq("idle_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
